// File: rtl/cart_mapper_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cart_mapper_if
// Description : 2600 cartridge-port bundle between the CPU/ROM side (master)
//               and the bankswitching mapper (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cart_mapper_if #(
   parameter int BANKS = 4
) ();
   localparam int BW = $clog2(BANKS);

   logic              ce;
   logic [12:0]       cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_dout;
   logic [12+BW-1:0]  rom_addr;
   logic [7:0]        rom_rdata;
   logic [BW-1:0]     bank;

   // CPU bus plus external ROM: drives address/data, receives mapped outputs
   modport master (
      output ce, cpu_addr, cpu_wdata, rom_rdata,
      input  cpu_dout, rom_addr, bank
   );

   // Mapper: decodes the CPU bus, addresses the ROM, returns read data
   modport slave (
      input  ce, cpu_addr, cpu_wdata, rom_rdata,
      output cpu_dout, rom_addr, bank
   );
endinterface
`default_nettype wire

// File: rtl/cart_mapper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cart_mapper
// Description : Atari F8/F6/F4 bankswitching cartridge responder. A cart
//               access to offset HOT_BASE+n (n < BANKS) selects 4 KB bank n.
//               Optional 128-byte Superchip RAM when CART_SUPERCHIP_EN is
//               defined (write $1000-$107F, read $1080-$10FF).
// Revision    : 1.0 - initial release
// ============================================================================
module cart_mapper #(
   parameter int          BANKS      = 4,
   parameter logic [11:0] HOT_BASE   = 12'hFF6,
   parameter int          RESET_BANK = BANKS - 1
) (
   input  wire logic    clk,
   input  wire logic    reset,
   cart_mapper_if.slave bus
);
   localparam int            BW           = $clog2(BANKS);
   localparam logic [BW-1:0] C_RESET_BANK = BW'(RESET_BANK);
   localparam logic [11:0]   C_BANKS      = 12'(BANKS);

   logic [BW-1:0] bank_q;
   logic [BW-1:0] bank_d;
   logic          cart_sel;
   logic [11:0]   offset;
   logic [11:0]   hot_delta;
   logic          hot_hit;

   // Hotspot decode and next-bank selection; no R/W line, so any cart access counts
   always_comb begin
      cart_sel  = bus.cpu_addr[12];
      offset    = bus.cpu_addr[11:0];
      hot_delta = offset - HOT_BASE;
      hot_hit   = (offset >= HOT_BASE) && (hot_delta < C_BANKS);
      bank_d    = bank_q;
      if (bus.ce && cart_sel && hot_hit) begin
         bank_d = hot_delta[BW-1:0];
      end
   end

   // Bank register; the hotspot access itself is still served from the old bank
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q <= C_RESET_BANK;
      end else begin
         bank_q <= bank_d;
      end
   end

   assign bus.rom_addr = {bank_q, offset};
   assign bus.bank     = bank_q;

`ifdef CART_SUPERCHIP_EN
   logic [7:0] ram [128];
   logic [7:0] ram_rd_q;
   logic [7:0] ram_rd_d;
   logic       ram_we;
   logic       ram_rd_win;

   // Superchip window decode; a CPU read of the write window still writes
   always_comb begin
      ram_we     = bus.ce && cart_sel && (bus.cpu_addr[11:7] == 5'b00000);
      ram_rd_win = cart_sel && (bus.cpu_addr[11:7] == 5'b00001);
      ram_rd_d   = ram[bus.cpu_addr[6:0]];
   end

   // RAM array write on the ce edge; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
      end
   end

   // Read register samples every clk, settling well inside the address setup
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_rd_q <= 8'h00;
      end else begin
         ram_rd_q <= ram_rd_d;
      end
   end

   assign bus.cpu_dout = ram_rd_win ? ram_rd_q : bus.rom_rdata;
`else
   // Without RAM, write data only matters for hotspot decoding, which ignores it
   logic unused_wdata;
   assign unused_wdata = ^bus.cpu_wdata;

   assign bus.cpu_dout = bus.rom_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cart_mapper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cart_mapper
// Description : Scoreboard bench for cart_mapper. Drives an F6 instance and an
//               F8 instance from one CPU bus, models ROM as a hashed byte
//               array with 1 clk latency, and checks every ce access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_mapper;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cart_mapper_if #(.BANKS(4)) if4 ();
   cart_mapper_if #(.BANKS(2)) if2 ();

   cart_mapper #(.BANKS(4), .HOT_BASE(12'hFF6), .RESET_BANK(3)) dut4 (
      .clk(clk), .reset(reset), .bus(if4.slave)
   );
   cart_mapper #(.BANKS(2), .HOT_BASE(12'hFF8), .RESET_BANK(1)) dut2 (
      .clk(clk), .reset(reset), .bus(if2.slave)
   );

   function automatic logic [7:0] rom_byte(input int a);
      return 8'((a * 37) ^ (a >> 4) ^ 8'h5C);
   endfunction

   // External ROMs: registered read, one clk latency
   always_ff @(posedge clk) begin
      if4.rom_rdata <= rom_byte(int'(if4.rom_addr));
      if2.rom_rdata <= rom_byte(int'(if2.rom_addr));
   end

   typedef struct {
      logic [7:0] dout4;
      logic [7:0] dout2;
      bit         chk_dout;
      int         rom_addr4;
      int         rom_addr2;
      int         bank4;
      int         bank2;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model state
   int         m_bank4 = 3;
   int         m_bank2 = 1;
   logic [7:0] m_ram    [128];
   bit         m_ram_ok [128];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int hot_n(input int off, input int base, input int banks);
      if (off >= base && off < base + banks) return off - base;
      return -1;
   endfunction

   task automatic drive(input logic [12:0] a, input logic [7:0] wd, input logic c);
      if4.cpu_addr = a; if4.cpu_wdata = wd; if4.ce = c;
      if2.cpu_addr = a; if2.cpu_wdata = wd; if2.ce = c;
   endtask

   // Compute the expected response of one ce access, then advance the model
   task automatic push_expect(input logic [12:0] a, input logic [7:0] wd, input bit chk_d);
      exp_t e;
      int   off  = int'(a[11:0]);
      bit   sel  = a[12];
      int   idx  = int'(a[6:0]);
      int   n;
      e.bank4     = m_bank4;
      e.bank2     = m_bank2;
      e.rom_addr4 = m_bank4 * 4096 + off;
      e.rom_addr2 = m_bank2 * 4096 + off;
      e.dout4     = rom_byte(e.rom_addr4);
      e.dout2     = rom_byte(e.rom_addr2);
      e.chk_dout  = chk_d && sel;
`ifdef CART_SUPERCHIP_EN
      if (sel && a[11:7] == 5'b00001) begin
         e.dout4    = m_ram[idx];
         e.dout2    = m_ram[idx];
         e.chk_dout = e.chk_dout && m_ram_ok[idx];
      end
      if (sel && a[11:7] == 5'b00000) begin
         m_ram[idx]    = wd;
         m_ram_ok[idx] = 1'b1;
      end
`endif
      n = hot_n(off, 'hFF6, 4);
      if (sel && n >= 0) m_bank4 = n;
      n = hot_n(off, 'hFF8, 2);
      if (sel && n >= 0) m_bank2 = n;
      q.push_back(e);
   endtask

   // One CPU cycle: address set up 2 clk ahead, then ce for 1 clk (2 if hold)
   task automatic cpu_cycle(input logic [12:0] a, input logic [7:0] wd, input bit hold);
      @(posedge clk); #1;
      drive(a, wd, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      push_expect(a, wd, 1'b1);
      drive(a, wd, 1'b1);
      if (hold) begin
         @(posedge clk); #1;
         push_expect(a, wd, 1'b0);
      end
      @(posedge clk); #1;
      drive(a, wd, 1'b0);
   endtask

   function automatic logic [12:0] rand_addr();
      case ($urandom_range(0, 4))
         0:       return 13'h1FF0 + 13'($urandom_range(0, 15));
         1:       return 13'h1000 + 13'($urandom_range(0, 7));
         2:       return 13'h1080 + 13'($urandom_range(0, 7));
         3:       return 13'h0FF0 + 13'($urandom_range(0, 15));
         default: return 13'($urandom);
      endcase
   endfunction

   // Monitor: every ce access outside reset is checked against the queue head
   always @(negedge clk) begin
      if (if4.ce === 1'b1 && reset === 1'b0) begin
         if (q.size() == 0) begin
            chk("unexpected_ce", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("bank4", 32'(if4.bank), 32'(e.bank4));
            chk("bank2", 32'(if2.bank), 32'(e.bank2));
            chk("rom_addr4", 32'(if4.rom_addr), 32'(e.rom_addr4));
            chk("rom_addr2", 32'(if2.rom_addr), 32'(e.rom_addr2));
            if (e.chk_dout) begin
               chk("cpu_dout4", 32'(if4.cpu_dout), 32'(e.dout4));
               chk("cpu_dout2", 32'(if2.cpu_dout), 32'(e.dout2));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(13'h1FFC, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_bank4", 32'(if4.bank), 32'd3);
      chk("rst_bank2", 32'(if2.bank), 32'd1);
      chk("rst_rom_addr4", 32'(if4.rom_addr), 32'h3FFC);
      chk("rst_rom_addr2", 32'(if2.rom_addr), 32'h1FFC);

      // Directed: F6 switching sequence and F8/F6 boundary offsets
      cpu_cycle(13'h1FFC, 8'h00, 1'b0);
      cpu_cycle(13'h1FF6, 8'h00, 1'b0);
      cpu_cycle(13'h1100, 8'h00, 1'b0);
      cpu_cycle(13'h1FF9, 8'h00, 1'b0);
      cpu_cycle(13'h1FFA, 8'h00, 1'b0);
      cpu_cycle(13'h1FF8, 8'h00, 1'b0);
      cpu_cycle(13'h0FF9, 8'h00, 1'b0);
      cpu_cycle(13'h0FF6, 8'h00, 1'b0);
      cpu_cycle(13'h1FF9, 8'h00, 1'b1);
      cpu_cycle(13'h1FF5, 8'h00, 1'b0);

      // Directed: Superchip window (or plain ROM when RAM is absent)
      cpu_cycle(13'h1005, 8'hA5, 1'b0);
      cpu_cycle(13'h1085, 8'h00, 1'b0);
      cpu_cycle(13'h1005, 8'h3C, 1'b1);
      cpu_cycle(13'h1085, 8'h00, 1'b0);
      cpu_cycle(13'h1185, 8'h00, 1'b0);

      // Reset coincident with ce on a hotspot: reset must win
      cpu_cycle(13'h1FF6, 8'h00, 1'b0);
      cpu_cycle(13'h1FF8, 8'h00, 1'b0);
      @(posedge clk); #1;
      drive(13'h1FF7, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      drive(13'h1FF7, 8'h00, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(13'h1FF7, 8'h00, 1'b0);
      m_bank4 = 3;
      m_bank2 = 1;
      chk("rst_ce_bank4", 32'(if4.bank), 32'd3);
      chk("rst_ce_bank2", 32'(if2.bank), 32'd1);

      // Random traffic with a mid-sequence reset
      for (int i = 0; i < 300; i++) begin
         cpu_cycle(rand_addr(), 8'($urandom), ($urandom_range(0, 7) == 0));
         if (i == 150) begin
            cpu_cycle(13'h1FF6, 8'h00, 1'b0);
            cpu_cycle(13'h1FF8, 8'h00, 1'b0);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            m_bank4 = 3;
            m_bank2 = 1;
            chk("mid_rst_bank4", 32'(if4.bank), 32'd3);
            chk("mid_rst_bank2", 32'(if2.bank), 32'd1);
         end
      end

      // Drain and final state
      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      #1;
      chk("final_bank4", 32'(if4.bank), 32'(m_bank4));
      chk("final_bank2", 32'(if2.bank), 32'(m_bank2));

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cart_mapper.md
# cart_mapper

Cartridge-side responder for the 2600 cartridge port: decodes the 13-bit CPU address, drives the external ROM address, and returns read data to the CPU data mux. Implements Atari-standard bankswitching (F8/F6/F4 by parameter): an access to a hotspot address selects the 4 KB bank. Optionally provides 128 bytes of Superchip RAM. It sits between the CPU's address/data bus and the cartridge ROM, in place of a direct connection from ROM address to CPU address.

## Interface
Parameters:
- BANKS, 4, number of 4 KB banks; legal values 2 (F8), 4 (F6), 8 (F4).
- HOT_BASE, 12'hFF6, offset of hotspot 0 within the 4 KB window. Use FF8 for F8, FF6 for F6, FF4 for F4.
- RESET_BANK, BANKS-1, bank selected after reset.

Ports (BW = $clog2(BANKS)):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  one-clk pulse per CPU cycle, coincident with the CPU enable; the address is stable for ≥2 clk before it.
- cpu_addr  in  13  CPU address bus.
- cpu_wdata  in  8  CPU write data.
- cpu_dout  out  8  read data to the CPU data mux; valid when cpu_addr[12]=1.
- rom_addr  out  12+BW  external ROM address = {bank, cpu_addr[11:0]}.
- rom_rdata  in  8  external ROM data, synchronous with ≤1 clk latency.
- bank  out  BW  current bank register, for debug/OSD.

## Operation
- Cartridge select is cpu_addr[12]=1. When cpu_addr[12]=0, state does not change, and cpu_dout is don't-care (it holds rom_rdata).
- Hotspot n is cpu_addr[11:0] = HOT_BASE+n, for 0≤n<BANKS. On ce with cart select asserted and a hotspot address present: bank <= n. Reads and writes behave alike, because the port carries no R/W line.
- Data for the hotspot access itself comes from the old bank. The switch takes effect on the clk edge that samples ce.
- An access to a non-hotspot address or an out-of-range offset leaves bank unchanged.
- rom_addr is combinational from bank and cpu_addr[11:0].
- cpu_dout = rom_rdata, except for the Superchip read window (see Configuration).
- State: bank register only, plus the RAM array and the RAM read register when CART_SUPERCHIP_EN is defined. There is no FSM beyond the bank register.

## Timing
- Reset values: bank = RESET_BANK; RAM read register = 8'h00. RAM contents are not reset.
- Bank update takes 1 clk after the ce edge. rom_addr reflects the new bank in the same cycle the register updates.
- RAM read register samples ram[cpu_addr[6:0]] on every clk edge. This gives 1 clk latency, which fits the ≥2-clk setup ahead of ce.
- A RAM write occurs on the ce edge. A read of the same location is valid 1 clk later.
- Reset asserted together with ce on a hotspot: reset wins, and bank = RESET_BANK.
- ce held high on consecutive clks with the same address: the repeated hotspot hit is idempotent. A repeated RAM write rewrites the same value.

## Configuration
- CART_SUPERCHIP_EN defined: 128×8 RAM is present.
  - Write window is cpu_addr[12]=1, cpu_addr[11:7]=5'b00000 ($1000–$107F). On ce, ram[cpu_addr[6:0]] <= cpu_wdata.
  - Read window is cpu_addr[11:7]=5'b00001 ($1080–$10FF). Here cpu_dout = RAM read register; otherwise cpu_dout = rom_rdata.
  - An access to the write window that is actually a CPU read still writes cpu_wdata, matching the hardware.
- CART_SUPERCHIP_EN undefined: there is no RAM and no read register. $1000–$10FF reads ROM like any other address, and writes have no effect other than hotspot decoding.

## Test plan
- Reset with BANKS=4: bank=3 and rom_addr={2'b11, addr}. Read $1FFC gives the byte at ROM 0x3FFC.
- ce at $1FF6 with F6 settings: the ROM data returned for that access comes from bank 3. Next, $1100 drives rom_addr=0x0100 and bank=0. Then $1FF9 selects bank 3.
- BANKS=2, HOT_BASE=FF8: $1FF6 and $1FFA leave bank unchanged; $1FF8 selects 0 and $1FF9 selects 1. Any access with cpu_addr[12]=0 at offset FF8 leaves bank unchanged.
- With CART_SUPERCHIP_EN: write 8'hA5 at $1005, then read $1085 → cpu_dout=8'hA5. Read $1005 overwrites the location with cpu_wdata. Read $1185 returns ROM data.
- Without CART_SUPERCHIP_EN: a write of 8'h5A at $1005 followed by a read of $1085 returns rom_rdata for 0x3085 (bank 3).
- Reset asserted in the same cycle as ce at $1FF7: bank=3 afterward. Reset asserted mid-sequence restores bank 3 on the next clk.
